data_mem_resp: RTL and testbench

//  Data-memory responder at the memory end of the load/store path. Accepts one byte-enabled

---
 rtl/data_mem_resp_pkg.sv | 26 ++
 rtl/data_mem_resp_if.sv | 22 ++
 rtl/dmem_byte_ram.sv | 42 ++++
 rtl/data_mem_resp.sv | 109 ++++++++++
 tb/tb_data_mem_resp.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
package data_mem_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [STRB_W-1:0] STRB_READ = 4'b0000;
  localparam logic [STRB_W-1:0] STRB_FULL = 4'b1111;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_EXEC = 2'b10,
    DMEM_RESP = 2'b11
  } dmem_state_e;

  // Request captured at accept and replayed at EXEC.
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_resp_if.sv
// Load/store handshake between the core's data-memory controller and the responder.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic              Mem_Req;
  logic [DATA_W-1:0] Mem_Addr;
  logic [STRB_W-1:0] Mem_Write_Ctrl;
  logic [DATA_W-1:0] Mem_Write_Data;
  logic              Mem_Ready;
  logic [DATA_W-1:0] Mem_Read_Data;
  logic              Mem_Err;

  modport master (
    output Mem_Req, Mem_Addr, Mem_Write_Ctrl, Mem_Write_Data,
    input  Mem_Ready, Mem_Read_Data, Mem_Err
  );

  modport slave (
    input  Mem_Req, Mem_Addr, Mem_Write_Ctrl, Mem_Write_Data,
    output Mem_Ready, Mem_Read_Data, Mem_Err
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// Four byte-lane synchronous RAMs with per-lane write enables and a registered read word.
// The read register returns zero on any cycle without a read so it can drive the bus directly.
module dmem_byte_ram
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [STRB_W-1:0]     we_i,
  input  logic                  re_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  for (genvar l = 0; l < STRB_W; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_d;
    logic [7:0] rd_q;

    always_comb begin
      rd_d = 8'h00;
      if (re_i) rd_d = mem_q[addr_i];
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (we_i[l]) mem_q[addr_i] <= wdata_i[8*l +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= 8'h00;
      else        rd_q <= rd_d;
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-enabled read/write with WAIT_STATES extra cycles before the response.
// Define DMEM_BOUNDS_CHECK_EN to flag addresses beyond the RAM depth instead of aliasing them.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  data_mem_resp_if.slave mem
);

  localparam bit HAS_WAIT = (WAIT_STATES != 0);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [STRB_W-1:0] ram_we_c;
  logic              ram_re_c;
  logic              oob_c;
  logic              unused_addr_c;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_c         = |req_q.addr[DATA_W-1:ADDR_WIDTH+2];
  assign unused_addr_c = ^req_q.addr[1:0];
`else
  assign oob_c         = 1'b0;
  assign unused_addr_c = ^{req_q.addr[DATA_W-1:ADDR_WIDTH+2], req_q.addr[1:0]};
`endif

  // State register plus capture/output flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Next state; the request is sampled only in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (mem.Mem_Req) begin
          req_d.addr  = mem.Mem_Addr;
          req_d.strb  = mem.Mem_Write_Ctrl;
          req_d.wdata = mem.Mem_Write_Data;
          if (HAS_WAIT) begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = DMEM_EXEC;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) state_d = DMEM_EXEC;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DMEM_EXEC: state_d = DMEM_RESP;
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // RAM access at EXEC; response flags land in the RESP cycle.
  always_comb begin
    ready_d  = 1'b0;
    err_d    = 1'b0;
    ram_we_c = STRB_READ;
    ram_re_c = 1'b0;
    if (state_q == DMEM_EXEC) begin
      ready_d = 1'b1;
      err_d   = oob_c;
      if (!oob_c) begin
        ram_we_c = req_q.strb;
        ram_re_c = (req_q.strb == STRB_READ);
      end
    end
  end

  dmem_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .addr_i  (req_q.addr[ADDR_WIDTH+1:2]),
    .we_i    (ram_we_c),
    .re_i    (ram_re_c),
    .wdata_i (req_q.wdata),
    .rdata_o (mem.Mem_Read_Data)
  );

  assign mem.Mem_Ready = ready_q;
  assign mem.Mem_Err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp at WAIT_STATES = 1, 0 and 15 sharing one clock and reset.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic        req_a   [3];
  logic [31:0] addr_a  [3];
  logic [3:0]  strb_a  [3];
  logic [31:0] wdata_a [3];
  logic        rdy_a   [3];
  logic [31:0] rd_a    [3];
  logic        err_a   [3];

  data_mem_resp_if bus0 ();
  data_mem_resp_if bus1 ();
  data_mem_resp_if bus2 ();

  assign bus0.Mem_Req = req_a[0];  assign bus0.Mem_Addr = addr_a[0];
  assign bus0.Mem_Write_Ctrl = strb_a[0];  assign bus0.Mem_Write_Data = wdata_a[0];
  assign rdy_a[0] = bus0.Mem_Ready;  assign rd_a[0] = bus0.Mem_Read_Data;  assign err_a[0] = bus0.Mem_Err;

  assign bus1.Mem_Req = req_a[1];  assign bus1.Mem_Addr = addr_a[1];
  assign bus1.Mem_Write_Ctrl = strb_a[1];  assign bus1.Mem_Write_Data = wdata_a[1];
  assign rdy_a[1] = bus1.Mem_Ready;  assign rd_a[1] = bus1.Mem_Read_Data;  assign err_a[1] = bus1.Mem_Err;

  assign bus2.Mem_Req = req_a[2];  assign bus2.Mem_Addr = addr_a[2];
  assign bus2.Mem_Write_Ctrl = strb_a[2];  assign bus2.Mem_Write_Data = wdata_a[2];
  assign rdy_a[2] = bus2.Mem_Ready;  assign rd_a[2] = bus2.Mem_Read_Data;  assign err_a[2] = bus2.Mem_Err;

  data_mem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(1))  u_dut_w1  (.Clk(clk), .Reset_n(rst_n), .mem(bus0));
  data_mem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(0))  u_dut_w0  (.Clk(clk), .Reset_n(rst_n), .mem(bus1));
  data_mem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(15)) u_dut_w15 (.Clk(clk), .Reset_n(rst_n), .mem(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request: returns response data, error flag and cycles from drive to Mem_Ready.
  task automatic access(input int sel, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input string tag,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clk); #1;
    req_a[sel] = 1'b1;  addr_a[sel] = a;  strb_a[sel] = s;  wdata_a[sel] = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy_a[sel] && lat < 40);
    chk({tag, "_ready_seen"}, 32'(rdy_a[sel]), 32'd1);
    rdata = rd_a[sel];
    err   = err_a[sel];
    req_a[sel] = 1'b0;  strb_a[sel] = 4'h0;  wdata_a[sel] = 32'h0;
    @(posedge clk); #1;
    chk({tag, "_pulse_width"}, 32'(rdy_a[sel]), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;
  int          pulses, last, extra;

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_a[i] = 1'b0;  addr_a[i] = 32'h0;  strb_a[i] = 4'h0;  wdata_a[i] = 32'h0;
    end
    rst_n = 1'b0;
    #12;
    chk("rst_ready",  32'(rdy_a[0]), 32'd0);
    chk("rst_rdata",  rd_a[0],       32'h0);
    chk("rst_err",    32'(err_a[0]), 32'd0);
    chk("rst_ready_w0",  32'(rdy_a[1]), 32'd0);
    chk("rst_ready_w15", 32'(rdy_a[2]), 32'd0);
    #10 rst_n = 1'b1;

    // Full-word store then load; 0x1000 lies past a 1K-word RAM.
    access(0, 32'h1000, STRB_FULL, 32'hCAFEBABE, "t1_sw", rd, er, lt);
    chk("t1_sw_lat", 32'(lt), 32'd3);
    chk("t1_sw_rdata", rd, 32'h0);
    chk("t1_sw_err", 32'(er), 32'(BCHK));
    access(0, 32'h1000, STRB_READ, 32'h0, "t1_lw", rd, er, lt);
    chk("t1_lw_lat", 32'(lt), 32'd3);
    chk("t1_lw_data", rd, BCHK ? 32'h0 : 32'hCAFEBABE);
    chk("t1_lw_err", 32'(er), 32'(BCHK));

    // Partial-lane merges.
    access(0, 32'h20, STRB_FULL, 32'h0, "t2_pre", rd, er, lt);
    access(0, 32'h20, 4'b0010, 32'h0000AB00, "t2_b1", rd, er, lt);
    chk("t2_b1_rdata", rd, 32'h0);
    access(0, 32'h20, 4'b1100, 32'h12340000, "t2_hi", rd, er, lt);
    access(0, 32'h20, STRB_READ, 32'h0, "t2_lw", rd, er, lt);
    chk("t2_lw_data", rd, 32'h1234AB00);
    access(0, 32'h22, 4'b1001, 32'h5600_0078, "t2_odd", rd, er, lt);
    access(0, 32'h20, STRB_READ, 32'h0, "t2_lw2", rd, er, lt);
    chk("t2_lw2_data", rd, 32'h5634AB78);

    // Back-to-back reads with Mem_Req held high.
    @(posedge clk); #1;
    req_a[0] = 1'b1;  addr_a[0] = 32'h1000;  strb_a[0] = STRB_READ;
    pulses = 0;  last = 0;
    for (int c = 1; c <= 40 && pulses < 4; c++) begin
      @(posedge clk); #1;
      if (rdy_a[0]) begin
        pulses++;
        chk("t3_data", rd_a[0], BCHK ? 32'h0 : 32'hCAFEBABE);
        chk("t3_gap", 32'(c - last), (pulses == 1) ? 32'd3 : 32'd4);
        last = c;
        if (pulses == 4) req_a[0] = 1'b0;
      end
    end
    req_a[0] = 1'b0;
    chk("t3_count", 32'(pulses), 32'd4);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rdy_a[0]) extra++;
    end
    chk("t3_extra", 32'(extra), 32'd0);

    // Reset while a store waits.
    access(0, 32'h40, STRB_FULL, 32'h0, "t4_pre", rd, er, lt);
    @(posedge clk); #1;
    req_a[0] = 1'b1;  addr_a[0] = 32'h40;  strb_a[0] = STRB_FULL;  wdata_a[0] = 32'hFFFFFFFF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t4_ready", 32'(rdy_a[0]), 32'd0);
    chk("t4_rdata", rd_a[0], 32'h0);
    chk("t4_err",   32'(err_a[0]), 32'd0);
    req_a[0] = 1'b0;  strb_a[0] = 4'h0;  wdata_a[0] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy_a[0]) extra++;
    end
    chk("t4_no_ready", 32'(extra), 32'd0);
    access(0, 32'h40, STRB_READ, 32'h0, "t4_lw", rd, er, lt);
    chk("t4_lw_data", rd, 32'h0);

    // Upper address bits: flagged when checked, aliased to word 0 otherwise.
    access(0, 32'h0, STRB_FULL, 32'h11111111, "t5_pre", rd, er, lt);
    chk("t5_pre_err", 32'(er), 32'd0);
    access(0, 32'h00001000, STRB_FULL, 32'h55AA55AA, "t5_sw", rd, er, lt);
    chk("t5_sw_err", 32'(er), 32'(BCHK));
    chk("t5_sw_lat", 32'(lt), 32'd3);
    access(0, 32'h0, STRB_READ, 32'h0, "t5_lw", rd, er, lt);
    chk("t5_lw_data", rd, BCHK ? 32'h11111111 : 32'h55AA55AA);
    chk("t5_lw_err", 32'(er), 32'd0);

    // Latency extremes.
    access(1, 32'hC, STRB_FULL, 32'h0BADF00D, "t6_w0_sw", rd, er, lt);
    chk("t6_w0_sw_lat", 32'(lt), 32'd2);
    access(1, 32'hC, STRB_READ, 32'h0, "t6_w0_lw", rd, er, lt);
    chk("t6_w0_lw_lat", 32'(lt), 32'd2);
    chk("t6_w0_lw_data", rd, 32'h0BADF00D);
    access(2, 32'h8, STRB_FULL, 32'hA5A50F0F, "t6_w15_sw", rd, er, lt);
    chk("t6_w15_sw_lat", 32'(lt), 32'd17);
    access(2, 32'h8, STRB_READ, 32'h0, "t6_w15_lw", rd, er, lt);
    chk("t6_w15_lw_lat", 32'(lt), 32'd17);
    chk("t6_w15_lw_data", rd, 32'hA5A50F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
